// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared types and constants for the 7-segment scan driver.
//               SEG_OFF   - all segments dark (active-low).
//               HEX_SEG   - hex-digit segment patterns, {g,f,e,d,c,b,a}.
//               seg_t     - 7-bit segment vector.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  // Active-low patterns for 0..F; lower-case b and d keep them distinct
  // from 8 and 0.
  localparam seg_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_7seg
// Description : Combinational nibble to active-low 7-segment pattern decode.
// Ports       : nibble_i  in  4  hex digit
//               seg_o     out 7  active-low segments {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule
`default_nettype wire

// File: rtl/display_scan_7seg.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_7seg
// Description : Time-multiplexed common-anode 7-segment driver with a
//               double-buffered load interface. New data is moved from the
//               pending buffer to the active buffer only at a frame boundary
//               so a frame never mixes old and new digits.
// Ports       : clk          in   1            system clock
//               reset        in   1            synchronous, active-high
//               load         in   1            capture value/dp_in/blank_in
//               value        in   4*N_DIGITS   nibble k drives digit k
//               dp_in        in   N_DIGITS     decimal point request per digit
//               blank_in     in   N_DIGITS     blank request per digit
//               anodes       out  N_DIGITS     active-low digit enables
//               segments     out  7            active-low {g,f,e,d,c,b,a}
//               dp           out  1            active-low decimal point
//               frame_start  out  1            pulse when digit 0 is lit
//               pending      out  1            loaded data awaiting boundary
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_7seg
  import display_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int SCAN_DIV = 100000
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  output logic [N_DIGITS-1:0]   anodes,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic                  frame_start,
  output logic                  pending
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = ($clog2(N_DIGITS) < 1) ? 1 : $clog2(N_DIGITS);

  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);

  // Scan state
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q,   idx_d;
  logic          lit_q,   lit_d;   // display has taken its first tick

  // Pending and active buffers
  logic [4*N_DIGITS-1:0] pend_val_q,   act_val_q;
  logic [N_DIGITS-1:0]   pend_dp_q,    act_dp_q;
  logic [N_DIGITS-1:0]   pend_blank_q, act_blank_q;
  logic                  pending_q;

  // Registered outputs
  logic [N_DIGITS-1:0] anodes_q,      anodes_d;
  seg_t                seg_q,         seg_d;
  logic                dp_q,          dp_d;
  logic                frame_start_q, frame_start_d;

  logic                  tick;
  logic                  boundary;
  logic                  swap;
  logic [4*N_DIGITS-1:0] src_val;
  logic [N_DIGITS-1:0]   src_dp;
  logic [N_DIGITS-1:0]   src_blank;
  logic [3:0]            nibble;
  seg_t                  dec_seg;

  assign tick     = (presc_q == PRESC_MAX);
  // idx_q is the lit digit once lit_q is set; the very first tick lights
  // digit 0 without advancing, so it is not a frame boundary.
  assign boundary = tick && lit_q && (idx_q == IDX_MAX);
  assign swap     = boundary && pending_q;

  // On a swapping boundary the digit-0 drive is taken straight from the
  // pending buffer, since the active buffer only updates on that same edge.
  assign src_val   = swap ? pend_val_q   : act_val_q;
  assign src_dp    = swap ? pend_dp_q    : act_dp_q;
  assign src_blank = swap ? pend_blank_q : act_blank_q;

  assign nibble = 4'(src_val >> {idx_d, 2'b00});

  hex_to_7seg u_hex_to_7seg (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  always_comb begin
    presc_d       = tick ? '0 : presc_q + 1'b1;
    idx_d         = idx_q;
    lit_d         = lit_q | tick;
    anodes_d      = anodes_q;
    seg_d         = seg_q;
    dp_d          = dp_q;
    frame_start_d = 1'b0;

    if (tick && lit_q) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    if (tick) begin
      anodes_d      = ~(N_DIGITS'(1) << idx_d);
      frame_start_d = (idx_d == '0);
      if (src_blank[idx_d]) begin
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
      end else begin
        seg_d = dec_seg;
        dp_d  = ~src_dp[idx_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q       <= '0;
      idx_q         <= '0;
      lit_q         <= 1'b0;
      pend_val_q    <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '0;
      pending_q     <= 1'b0;
      act_val_q     <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '0;
      anodes_q      <= '1;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      lit_q         <= lit_d;
      anodes_q      <= anodes_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;

      // The boundary consumes what was pending before this edge; a load on
      // the same edge refills the pending buffer and keeps the flag set.
      if (swap) begin
        act_val_q   <= pend_val_q;
        act_dp_q    <= pend_dp_q;
        act_blank_q <= pend_blank_q;
      end

      if (load) begin
        pend_val_q   <= value;
        pend_dp_q    <= dp_in;
        pend_blank_q <= blank_in;
        pending_q    <= 1'b1;
      end else if (swap) begin
        pending_q    <= 1'b0;
      end
    end
  end

  assign anodes      = anodes_q;
  assign segments    = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_7seg.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_7seg
// Description : Self-checking bench for display_scan_7seg, N_DIGITS=4,
//               SCAN_DIV=4. Expected per-digit drive is queued at load time
//               and compared frame by frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_7seg;

  localparam int N_DIGITS = 4;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic        dp;
  logic        frame_start;
  logic        pending;

  int checks   = 0;
  int failures = 0;

  display_scan_7seg #(
    .N_DIGITS (N_DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .value       (value),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .anodes      (anodes),
    .segments    (segments),
    .dp          (dp),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dpo;
  } exp_digit_t;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dpv;
    logic [3:0]  blank;
    logic [6:0]  seg [4];
    logic [3:0]  dpo;
  } vec_t;

  exp_digit_t exp_q [$];
  vec_t       vecs [5];

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;
      4'h3: return 7'h30;  4'h4: return 7'h19;  4'h5: return 7'h12;
      4'h6: return 7'h02;  4'h7: return 7'h78;  4'h8: return 7'h00;
      4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Push expected frame from the bench's own decode model.
  task automatic push_model(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    exp_digit_t e;
    for (int k = 0; k < 4; k++) begin
      e.an  = ~(4'b0001 << k);
      e.seg = b[k] ? 7'h7F : ref_seg(v[4*k +: 4]);
      e.dpo = b[k] ? 1'b1 : ~d[k];
      exp_q.push_back(e);
    end
  endtask

  task automatic push_vec(input vec_t t);
    exp_digit_t e;
    for (int k = 0; k < 4; k++) begin
      e.an  = ~(4'b0001 << k);
      e.seg = t.seg[k];
      e.dpo = t.dpo[k];
      exp_q.push_back(e);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value    = v;
    dp_in    = d;
    blank_in = b;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic wait_frame_start(input int budget);
    int n = 0;
    while (frame_start !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_start_wait", {31'd0, frame_start}, 32'd1);
  endtask

  // Starts on the cycle digit 0 becomes lit; ends one frame later.
  task automatic check_frame(input string tag);
    exp_digit_t e;
    for (int d = 0; d < 4; d++) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_queue: actual=empty required=entry", tag);
        repeat (SCAN_DIV) @(negedge clk);
      end else begin
        e = exp_q.pop_front();
        for (int c = 0; c < SCAN_DIV; c++) begin
          chk({tag, "_anodes"},   {28'd0, anodes},   {28'd0, e.an});
          chk({tag, "_segments"}, {25'd0, segments}, {25'd0, e.seg});
          chk({tag, "_dp"},       {31'd0, dp},       {31'd0, e.dpo});
          chk({tag, "_fstart"},   {31'd0, frame_start}, {31'd0, (d == 0 && c == 0)});
          @(negedge clk);
        end
      end
    end
  endtask

  // Called at the negedge where reset is released; ends on digit 0 cycle 1.
  task automatic check_release(input string tag);
    @(negedge clk);
    for (int k = 1; k < SCAN_DIV; k++) begin
      chk({tag, "_dark_anodes"},   {28'd0, anodes},   32'hF);
      chk({tag, "_dark_segments"}, {25'd0, segments}, 32'h7F);
      chk({tag, "_dark_dp"},       {31'd0, dp},       32'd1);
      chk({tag, "_dark_pending"},  {31'd0, pending},  32'd0);
      chk({tag, "_dark_fstart"},   {31'd0, frame_start}, 32'd0);
      @(negedge clk);
    end
    chk({tag, "_first_anodes"},   {28'd0, anodes},   32'hE);
    chk({tag, "_first_fstart"},   {31'd0, frame_start}, 32'd1);
    chk({tag, "_first_segments"}, {25'd0, segments}, 32'h40);
    chk({tag, "_first_dp"},       {31'd0, dp},       32'd1);
    @(negedge clk);
    chk({tag, "_fstart_pulse"},   {31'd0, frame_start}, 32'd0);
    chk({tag, "_still_digit0"},   {28'd0, anodes},   32'hE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0].value = 16'h1234; vecs[0].dpv = 4'b0010; vecs[0].blank = 4'b0000;
    vecs[0].seg   = '{7'h19, 7'h30, 7'h24, 7'h79};     vecs[0].dpo = 4'b1101;
    vecs[1].value = 16'h8888; vecs[1].dpv = 4'b0000; vecs[1].blank = 4'b1000;
    vecs[1].seg   = '{7'h00, 7'h00, 7'h00, 7'h7F};     vecs[1].dpo = 4'b1111;
    vecs[2].value = 16'h90E5; vecs[2].dpv = 4'b1001; vecs[2].blank = 4'b0100;
    vecs[2].seg   = '{7'h12, 7'h06, 7'h7F, 7'h10};     vecs[2].dpo = 4'b0110;
    vecs[3].value = 16'hC7F6; vecs[3].dpv = 4'b0000; vecs[3].blank = 4'b0000;
    vecs[3].seg   = '{7'h02, 7'h0E, 7'h78, 7'h46};     vecs[3].dpo = 4'b1111;
    vecs[4].value = 16'h0000; vecs[4].dpv = 4'b1111; vecs[4].blank = 4'b0011;
    vecs[4].seg   = '{7'h7F, 7'h7F, 7'h40, 7'h40};     vecs[4].dpo = 4'b0011;

    reset = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_in = '0;

    // Reset and release
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_anodes",   {28'd0, anodes},   32'hF);
    chk("reset_segments", {25'd0, segments}, 32'h7F);
    chk("reset_pending",  {31'd0, pending},  32'd0);
    reset = 1'b0;
    check_release("rel");

    // Table-driven frames: load, verify pending, verify whole next frame
    for (int i = 0; i < 5; i++) begin
      do_load(vecs[i].value, vecs[i].dpv, vecs[i].blank);
      chk("vec_pending_set", {31'd0, pending}, 32'd1);
      push_vec(vecs[i]);
      wait_frame_start(40);
      chk("vec_pending_clr", {31'd0, pending}, 32'd0);
      check_frame("vec");
    end

    // Tear-free update: ABCD loaded while digit 1 of 1234 is lit
    do_load(16'h1234, 4'b0000, 4'b0000);
    push_model(16'h1234, 4'b0000, 4'b0000);
    wait_frame_start(40);
    check_frame("tear_setup");
    repeat (4) @(negedge clk);
    chk("tear_digit1", {28'd0, anodes}, 32'hD);
    do_load(16'hABCD, 4'b0000, 4'b0000);
    push_model(16'hABCD, 4'b0000, 4'b0000);
    chk("tear_pending", {31'd0, pending}, 32'd1);
    repeat (3) @(negedge clk);
    chk("tear_d2_anodes", {28'd0, anodes},   32'hB);
    chk("tear_d2_seg",    {25'd0, segments}, 32'h24);
    chk("tear_d2_pend",   {31'd0, pending},  32'd1);
    repeat (4) @(negedge clk);
    chk("tear_d3_anodes", {28'd0, anodes},   32'h7);
    chk("tear_d3_seg",    {25'd0, segments}, 32'h79);
    chk("tear_d3_pend",   {31'd0, pending},  32'd1);
    repeat (4) @(negedge clk);
    chk("tear_boundary_fs",   {31'd0, frame_start}, 32'd1);
    chk("tear_boundary_pend", {31'd0, pending},     32'd0);
    check_frame("tear");

    // Load on boundary: 5555 loaded on the index-3 tick while 1111 pends
    do_load(16'h1111, 4'b0000, 4'b0000);
    push_model(16'h1111, 4'b0000, 4'b0000);
    repeat (14) @(negedge clk);
    chk("lob_last_cycle_anodes", {28'd0, anodes}, 32'h7);
    do_load(16'h5555, 4'b0000, 4'b0000);
    push_model(16'h5555, 4'b0000, 4'b0000);
    chk("lob_fs",      {31'd0, frame_start}, 32'd1);
    chk("lob_pending", {31'd0, pending},     32'd1);
    check_frame("lob_1111");
    chk("lob_pending_clr", {31'd0, pending}, 32'd0);
    check_frame("lob_5555");

    // Reset mid-frame with data pending
    do_load(16'h7777, 4'b0000, 4'b0000);
    repeat (7) @(negedge clk);
    chk("mid_digit2", {28'd0, anodes}, 32'hB);
    chk("mid_pending_before", {31'd0, pending}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_anodes",   {28'd0, anodes},   32'hF);
    chk("mid_segments", {25'd0, segments}, 32'h7F);
    chk("mid_dp",       {31'd0, dp},       32'd1);
    chk("mid_pending",  {31'd0, pending},  32'd0);
    chk("mid_fstart",   {31'd0, frame_start}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_release("mid_rel");
    push_model(16'h0000, 4'b0000, 4'b0000);
    wait_frame_start(40);
    check_frame("mid_zero");
    chk("mid_final_pending", {31'd0, pending},  32'd0);
    chk("mid_final_seg",     {25'd0, segments}, 32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
